// File: rtl/postage_sched_pkg.sv
// Shared defaults and types for the postage capture scheduler.
package postage_sched_pkg;

  localparam int DEF_N_REQ   = 8;
  localparam int DEF_N_SLOTS = 4;
  localparam int SRC_W       = $clog2(DEF_N_REQ);
  localparam int SLOT_W      = $clog2(DEF_N_SLOTS);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [SLOT_W-1:0] slot;
  } grant_t;

endpackage

// File: rtl/postage_rr_arbiter.sv
// Rotating-priority encoder: finds the first set request at or above ptr,
// wrapping modulo N. Purely combinational.
module postage_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan candidates in rotation order starting at ptr; first hit wins.
  always_comb begin
    logic [IDX_W:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/postage_capture_scheduler.sv
// Latches per-channel trigger pulses and grants pending channels a free
// capture slot round-robin; each grant holds its slot for STAMP_LEN cycles.
module postage_capture_scheduler
  import postage_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int N_SLOTS   = DEF_N_SLOTS,
  parameter int STAMP_LEN = 127,
  parameter int CNT_W     = 8,
  parameter int DROP_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req,
  input  logic                       clear_drops,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_src,
  output logic [$clog2(N_SLOTS)-1:0] grant_slot,
  output logic [N_SLOTS-1:0]         slot_busy,
  output logic [N_REQ-1:0]           pending,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int RW = $clog2(N_REQ);
  localparam int KW = $clog2(N_SLOTS);

  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [N_SLOTS];
  logic [CNT_W-1:0]  cnt_d [N_SLOTS];
  logic              grant_valid_q, grant_valid_d;
  logic [RW-1:0]     grant_src_q, grant_src_d;
  logic [KW-1:0]     grant_slot_q, grant_slot_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              arb_found;
  logic [RW-1:0]     arb_idx;
  logic              slot_found;
  logic [KW-1:0]     slot_idx;
  logic              do_grant;
  logic [N_REQ-1:0]  granted_bit;

  postage_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (RW)
  ) u_arb (
    .req   (pending_q),
    .ptr   (rr_ptr_q),
    .found (arb_found),
    .idx   (arb_idx)
  );

  // Lowest-index free slot.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (!slot_found && cnt_q[k] == '0) begin
        slot_found = 1'b1;
        slot_idx   = KW'(k);
      end
    end
  end

  // Grant decision, grant register and round-robin pointer update.
  always_comb begin
    do_grant      = enable && arb_found && slot_found;
    granted_bit   = '0;
    grant_valid_d = do_grant;
    grant_src_d   = grant_src_q;
    grant_slot_d  = grant_slot_q;
    rr_ptr_d      = rr_ptr_q;
    if (do_grant) begin
      granted_bit[arb_idx] = 1'b1;
      grant_src_d          = arb_idx;
      grant_slot_d         = slot_idx;
      rr_ptr_d             = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + RW'(1);
    end
  end

  // Pending latch and saturating drop count; a re-trigger on an
  // already-pending, not-granted channel is a lost trigger.
  always_comb begin
    pending_d = (pending_q & ~granted_bit) | req;
    drop_d    = drop_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i] && pending_q[i] && !granted_bit[i] && drop_d != '1) begin
        drop_d = drop_d + DROP_W'(1);
      end
    end
    if (clear_drops) begin
      drop_d = '0;
    end
  end

  // Slot busy counters: load on grant, otherwise count down to zero.
  always_comb begin
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      cnt_d[k] = (cnt_q[k] != '0) ? cnt_q[k] - CNT_W'(1) : '0;
      if (do_grant && slot_idx == KW'(k)) begin
        cnt_d[k] = CNT_W'(STAMP_LEN);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_src_q   <= '0;
      grant_slot_q  <= '0;
      drop_q        <= '0;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_src_q   <= grant_src_d;
      grant_slot_q  <= grant_slot_d;
      drop_q        <= drop_d;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Slot busy flags straight from the counters.
  always_comb begin
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      slot_busy[k] = (cnt_q[k] != '0);
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_src   = grant_src_q;
  assign grant_slot  = grant_slot_q;
  assign pending     = pending_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_postage_capture_scheduler.sv
// Scoreboard bench for postage_capture_scheduler against a cycle-level
// reference model built from slot free-times and a pending set.
module tb_postage_capture_scheduler;
  import postage_sched_pkg::*;

  localparam int N     = 8;
  localparam int K     = 4;
  localparam int STAMP = 127;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear_drops;
  logic [7:0]  req;
  logic        grant_valid;
  logic [2:0]  grant_src;
  logic [1:0]  grant_slot;
  logic [3:0]  slot_busy;
  logic [7:0]  pending;
  logic [15:0] drop_count;

  typedef struct {
    grant_t g;
    int     cyc;
  } exp_t;

  exp_t     q[$];
  int       checks   = 0;
  int       failures = 0;
  int       cyc      = 0;

  bit [7:0] m_pend;
  int       m_ptr;
  int       m_free [K];
  int       m_drops;

  postage_capture_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .clear_drops (clear_drops),
    .grant_valid (grant_valid),
    .grant_src   (grant_src),
    .grant_slot  (grant_slot),
    .slot_busy   (slot_busy),
    .pending     (pending),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ptr   = 0;
    m_drops = 0;
    for (int k = 0; k < K; k++) m_free[k] = 0;
  endtask

  // One cycle of the reference: grant choice from the current state, then
  // drop accounting and pending update using this cycle's inputs.
  task automatic model_step(input logic [7:0] r, input logic en, input logic clr);
    int   gs;
    int   gk;
    int   idx;
    exp_t e;
    gs = -1;
    gk = -1;
    if (en) begin
      for (int k = K - 1; k >= 0; k--) if (m_free[k] <= cyc) gk = k;
      if (gk >= 0) begin
        for (int j = N - 1; j >= 0; j--) begin
          idx = (m_ptr + j) % N;
          if (m_pend[idx]) gs = idx;
        end
      end
      if (gs < 0) gk = -1;
    end
    if (gs >= 0) begin
      e.g.src  = SRC_W'(gs);
      e.g.slot = SLOT_W'(gk);
      e.cyc    = cyc + 1;
      q.push_back(e);
      m_free[gk] = cyc + STAMP + 1;
      m_ptr      = (gs + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (r[i] && m_pend[i] && i != gs) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
    end
    if (clr) m_drops = 0;
    for (int i = 0; i < N; i++) m_pend[i] = (m_pend[i] && i != gs) || r[i];
  endtask

  task automatic check_state();
    logic [3:0] busy_m;
    for (int k = 0; k < K; k++) busy_m[k] = (cyc < m_free[k]);
    chk("pending", pending, m_pend);
    chk("slot_busy", slot_busy, busy_m);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic cycle(input logic [7:0] r, input logic en, input logic clr);
    @(posedge clock);
    #1;
    cyc++;
    check_state();
    req         = r;
    enable      = en;
    clear_drops = clr;
    model_step(r, en, clr);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant_valid"}, grant_valid, 0);
    chk({tag, "_grant_src"}, grant_src, 0);
    chk({tag, "_grant_slot"}, grant_slot, 0);
    chk({tag, "_slot_busy"}, slot_busy, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    q.delete();
    req         = '0;
    clear_drops = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a grant is due or presented.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (q.size() != 0 && q[0].cyc == cyc) begin
          exp_t e;
          e = q.pop_front();
          chk("grant_valid", grant_valid, 1);
          chk("grant_src", grant_src, e.g.src);
          chk("grant_slot", grant_slot, e.g.slot);
        end else if (grant_valid) begin
          chk("unexpected_grant", grant_valid, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    reset       = 1'b1;
    enable      = 1'b0;
    req         = '0;
    clear_drops = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single request on channel 3 with all slots idle.
    cycle(8'h08, 1'b1, 1'b0);
    repeat (135) cycle(8'h00, 1'b1, 1'b0);

    // All channels at once: four grants, then the rest as slots free.
    cycle(8'hFF, 1'b1, 1'b0);
    repeat (300) cycle(8'h00, 1'b1, 1'b0);

    // Pointer to 6 via a grant on channel 5, then pending {1,2,7}.
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h86, 1'b1, 1'b0);
    repeat (5) cycle(8'h00, 1'b1, 1'b0);

    // All slots busy: channel 5 re-triggered twice while pending.
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    chk("drops_two", drop_count, 2);
    repeat (140) cycle(8'h00, 1'b1, 1'b0);

    // Drive the drop counter into saturation, then clear with a drop.
    repeat (9400) cycle(8'hFF, 1'b1, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0);
    chk("drops_saturated", drop_count, 16'hFFFF);
    cycle(8'hFF, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b0);
    chk("drops_cleared", drop_count, 0);
    repeat (600) cycle(8'h00, 1'b1, 1'b0);

    // Async reset mid-stamp with pending requests and a nonzero drop count.
    cycle(8'hFF, 1'b1, 1'b0);
    cycle(8'hF0, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    mid_reset();
    repeat (20) cycle(8'h00, 1'b1, 1'b0);

    // Randomised traffic with enable toggling and occasional clears.
    repeat (3000) begin
      r = 8'($urandom & $urandom & $urandom);
      cycle(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
    end

    // Drain outstanding grants.
    for (int i = 0; i < 400 && q.size() != 0; i++) cycle(8'h00, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
